framed_shift_register: RTL



---
 rtl/framed_shift_register_pkg.sv | 25 ++
 rtl/framed_shift_register_sr_frame_ctr.sv | 78 +++++++
 rtl/framed_shift_register.sv | 134 +++++++++++++
 3 files changed

// File: rtl/framed_shift_register_pkg.sv
// framed_shift_register_pkg: shared definitions for the framed shift register.
// Shift direction encodings, frame tracker state type and a constant clog2.
package framed_shift_register_pkg;

  // Encodings used on the dir input.
  localparam logic SHIFT_DIR_LEFT  = 1'b0;
  localparam logic SHIFT_DIR_RIGHT = 1'b1;

  // Frame tracker states: IDLE means no shift accepted in the current frame.
  typedef enum logic [0:0] {
    FRAME_IDLE     = 1'b0,
    FRAME_SHIFTING = 1'b1
  } frame_state_e;

  // Ceiling log2 for sizing counters at elaboration time.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/framed_shift_register_sr_frame_ctr.sv
// framed_shift_register_sr_frame_ctr: counts accepted shifts within a frame
// and strobes frame_done for one cycle after the frame's last shift.
// frame_wrap is the combinational "this edge completes a frame" flag used by
// the parent to capture the completed word on the same edge.
module framed_shift_register_sr_frame_ctr
  import framed_shift_register_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             frame_done,
  output logic             frame_wrap
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  frame_state_e     state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             done_r, done_s;
  logic             wrap_s;

  // State, count and strobe registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FRAME_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic: clear restarts the frame, an accepted shift advances it.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    wrap_s  = 1'b0;
    if (clr) begin
      state_s = FRAME_IDLE;
      cnt_s   = {CNT_W{1'b0}};
    end else if (shift_en) begin
      case (state_r)
        FRAME_IDLE, FRAME_SHIFTING: begin
          if (cnt_r == LAST_CNT) begin
            // Last shift of the frame (or every shift when FRAME_LEN is 1).
            state_s = FRAME_IDLE;
            cnt_s   = {CNT_W{1'b0}};
            done_s  = 1'b1;
            wrap_s  = 1'b1;
          end else begin
            state_s = FRAME_SHIFTING;
            cnt_s   = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = FRAME_IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  assign frame_cnt  = cnt_r;
  assign frame_done = done_r;
  assign frame_wrap = wrap_s;

endmodule

// File: rtl/framed_shift_register.sv
// framed_shift_register: universal shift register (left/right shift, parallel
// load, serial out) with a frame tracker that captures each completed word.
// Optional feature macro: FRAMED_SR_PARITY_EN adds a registered odd-parity
// output over the sin bits of each completed frame.
module framed_shift_register
  import framed_shift_register_pkg::*;
#(
  parameter int             W         = 8,
  parameter int             SHIFT_W   = 1,
  parameter logic [W-1:0]   RESET_VAL = {W{1'b0}},
  parameter int             FRAME_LEN = W / SHIFT_W,
  localparam int            CNT_W     = clog2(FRAME_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               load,
  input  logic [W-1:0]       load_d,
  input  logic               shift_en,
  input  logic               dir,
  input  logic [SHIFT_W-1:0] sin,
  output logic [W-1:0]       q,
  output logic [SHIFT_W-1:0] sout,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               frame_done,
`ifdef FRAMED_SR_PARITY_EN
  output logic               parity,
`endif
  output logic [W-1:0]       word
);

  logic [W-1:0] q_r;
  logic [W-1:0] word_r;
  logic [W-1:0] q_shift_s;
  logic         frame_rst_s;
  logic         wrap_s;

  // Load and clear both restart the frame and discard a simultaneous shift.
  assign frame_rst_s = clr | load;

  framed_shift_register_sr_frame_ctr #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_sr_frame_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr        (frame_rst_s),
    .shift_en   (shift_en),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done),
    .frame_wrap (wrap_s)
  );

  // Post-shift register value for the current direction.
  always_comb begin
    q_shift_s = q_r;
    if (dir == SHIFT_DIR_RIGHT) begin
      q_shift_s = {sin, q_r[W-1:SHIFT_W]};
    end else begin
      q_shift_s = {q_r[W-1-SHIFT_W:0], sin};
    end
  end

  // Serial output: the bits that would leave on the next shift.
  always_comb begin
    sout = {SHIFT_W{1'b0}};
    if (dir == SHIFT_DIR_LEFT) begin
      sout = q_r[W-1 -: SHIFT_W];
    end else begin
      sout = q_r[SHIFT_W-1:0];
    end
  end

  // Main data register with clear > load > shift priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= RESET_VAL;
    end else if (clr) begin
      q_r <= RESET_VAL;
    end else if (load) begin
      q_r <= load_d;
    end else if (shift_en) begin
      q_r <= q_shift_s;
    end else begin
      q_r <= q_r;
    end
  end

  // Completed-word capture; wrap is already suppressed by clear/load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_r <= RESET_VAL;
    end else if (wrap_s) begin
      word_r <= q_shift_s;
    end else begin
      word_r <= word_r;
    end
  end

  assign q    = q_r;
  assign word = word_r;

`ifdef FRAMED_SR_PARITY_EN
  logic par_run_r;
  logic par_r;

  // Odd-parity bit over a running XOR plus the incoming bits.
  function automatic logic odd_par_bit(input logic run,
                                       input logic [SHIFT_W-1:0] bits);
    return ~(run ^ (^bits));
  endfunction

  // Running XOR of accepted sin bits; captured as odd parity at completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_run_r <= 1'b0;
      par_r     <= 1'b0;
    end else if (frame_rst_s) begin
      par_run_r <= 1'b0;
      par_r     <= 1'b0;
    end else if (wrap_s) begin
      par_r     <= odd_par_bit(par_run_r, sin);
      par_run_r <= 1'b0;
    end else if (shift_en) begin
      par_run_r <= par_run_r ^ (^sin);
    end else begin
      par_run_r <= par_run_r;
    end
  end

  assign parity = par_r;
`endif

endmodule
